mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 Parameter: ZERO_BYPASS, default 1, nonzero = skip multiplier when either operand is zero.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request from execute stage.
REQ-005 in_ready  out  1  block can accept; equals (state==IDLE).
REQ-006 in_funct3  in  3  RV32M op; [1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored.
REQ-007 in_rs1, in_rs2  in  32 each  source operands.
REQ-008 in_rd  in  5  destination tag, returned unchanged.
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  writeback accepts result.
REQ-011 out_result  out  32  final RV32M result.
REQ-012 out_rd  out  5  tag of out_result.
REQ-013 mul_op1, mul_op2  out  32 each  unsigned magnitudes to multiplier.
REQ-014 mul_vld  out  1  launch request to multiplier.
REQ-015 mul_res  in  64  unsigned product from multiplier.
REQ-016 mul_rdy  in  1  multiplier product valid.

Function
REQ-017 FSM states IDLE, BUSY, DONE; one request in flight at most.
REQ-018 IDLE: on in_valid&in_ready, register funct3, rd, operand magnitudes, sign flag at that edge.
REQ-019 Signedness: MUL unsigned/unsigned (low word identical); MULH signed/signed; MULHSU rs1 signed, rs2 unsigned; MULHU unsigned/unsigned.
REQ-020 Magnitude of signed negative operand = two's-complement negation, 32-bit; 0x80000000 maps to 0x80000000 unsigned.
REQ-021 Sign flag = XOR of operand signs treated as signed; 0 for unsigned operands.
REQ-022 ZERO_BYPASS!=0 and either operand zero at accept: IDLE->DONE directly, out_result=0, mul_vld never asserted.
REQ-023 Otherwise IDLE->BUSY; mul_vld=1 throughout BUSY, mul_op1/mul_op2 stable throughout BUSY.
REQ-024 BUSY with mul_rdy=1: product = sign ? (~mul_res+1) mod 2^64 : mul_res; register product[31:0] for MUL, product[63:32] otherwise; go DONE.
REQ-025 BUSY with mul_rdy=0: remain BUSY indefinitely; no timeout.
REQ-026 mul_vld=0 in IDLE and DONE, guaranteeing >=1 low cycle between launches.
REQ-027 DONE: out_valid=1; out_result, out_rd held stable until out_valid&out_ready.
REQ-028 DONE with out_ready=1: ->IDLE; in_ready rises next cycle (no same-cycle accept).
REQ-029 mul_rdy outside BUSY ignored.
REQ-030 Latency: accept edge N; mul_rdy sampled at edge M; out_valid high from cycle after M. Bypass: out_valid high cycle after N.

Reset
REQ-031 rst at any edge: state IDLE; out_valid, mul_vld, out_result, out_rd, mul_op1, mul_op2 = 0; in_ready=1 after reset edge.
REQ-032 Reset during BUSY or DONE abandons request; no out_valid for it; later mul_rdy ignored per REQ-029.

Structure
REQ-033 Shared package mul_pkg: funct3[1:0] encodings, FSM state enum, XLEN=32 constant.
REQ-034 One sub-module mul_sign_fix (combinational): 64-bit conditional negate plus high/low word select; FSM and registers in mul_ctrl.

Verification
REQ-035 MUL rs1=7, rs2=0xFFFFFFFD (-3), multiplier model 4-cycle -> out_result 0xFFFFFFEB, out_rd echoed.
REQ-036 MULH 0x80000000 x 0x80000000 -> mul_op1=mul_op2=0x80000000, out_result 0x40000000.
REQ-037 MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> out_result 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-038 ZERO_BYPASS=1, MULH rs1=0, rs2=5 -> mul_vld stays 0, out_valid cycle after accept, out_result 0.
REQ-039 Backpressure: out_ready low 5 cycles in DONE -> out_result/out_rd stable, in_ready 0, in_valid not accepted.
REQ-040 rst pulsed during BUSY, then mul_rdy=1 -> no out_valid, mul_vld 0, in_ready 1 following reset edge.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared RV32M multiply encodings, FSM state and helpers
package mul_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] F_MUL    = 2'b00;
    localparam logic [1:0] F_MULH   = 2'b01;
    localparam logic [1:0] F_MULHSU = 2'b10;
    localparam logic [1:0] F_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? ((~v) + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - conditional 64-bit negate of the product and result word select
module mul_sign_fix
    import mul_pkg::*;
(
    input  logic [2*XLEN-1:0] prod,
    input  logic              negate,
    input  logic              hi_sel,
    output logic [XLEN-1:0]   word
);

    logic [2*XLEN-1:0] fixed;

    always_comb begin
        fixed = negate ? ((~prod) + (2*XLEN)'(1)) : prod;
        word  = hi_sel ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
    end

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - RV32M multiply sequencer around an external unsigned multiplier
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int ZERO_BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   mul_op1,
    output logic [XLEN-1:0]   mul_op2,
    output logic              mul_vld,
    input  logic [2*XLEN-1:0] mul_res,
    input  logic              mul_rdy
);

    state_e            state_q, state_d;
    logic [1:0]        funct_q, funct_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              rs1_signed, rs2_signed;
    logic              in_sign;
    logic              bypass;
    logic [XLEN-1:0]   fixed_word;
    logic              unused_funct3_msb;

    assign unused_funct3_msb = in_funct3[2];

    always_comb begin
        rs1_signed = (in_funct3[1:0] == F_MULH) || (in_funct3[1:0] == F_MULHSU);
        rs2_signed = (in_funct3[1:0] == F_MULH);
        in_sign    = (rs1_signed & in_rs1[XLEN-1]) ^ (rs2_signed & in_rs2[XLEN-1]);
        bypass     = (ZERO_BYPASS != 0) && ((in_rs1 == '0) || (in_rs2 == '0));
    end

    mul_sign_fix u_sign_fix (
        .prod   (mul_res),
        .negate (sign_q),
        .hi_sel (funct_q != F_MUL),
        .word   (fixed_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct_q  <= F_MUL;
            rd_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            rd_q     <= rd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = bypass ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mul_rdy) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only at accept and then held through BUSY/DONE
    always_comb begin
        funct_d  = funct_q;
        rd_d     = rd_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sign_d   = sign_q;
        result_d = result_q;
        if (state_q == ST_IDLE && in_valid) begin
            funct_d = in_funct3[1:0];
            rd_d    = in_rd;
            op1_d   = magnitude(in_rs1, rs1_signed);
            op2_d   = magnitude(in_rs2, rs2_signed);
            sign_d  = in_sign;
            if (bypass) result_d = '0;
        end else if (state_q == ST_BUSY && mul_rdy) begin
            result_d = fixed_word;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        mul_vld   = (state_q == ST_BUSY);
        out_valid = (state_q == ST_DONE);
    end

    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign mul_op1    = op1_q;
    assign mul_op2    = op2_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - randomized and directed bench for mul_ctrl against a transaction-level model
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [31:0] mul_op1, mul_op2;
    logic        mul_vld;
    logic [63:0] mul_res = '0;
    logic        mul_rdy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;

    mul_ctrl #(.ZERO_BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_vld    (mul_vld),
        .mul_res    (mul_res),
        .mul_rdy    (mul_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Reference RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            2'b00:   p = 64'(ua * ub);
            2'b01:   p = 64'(sa * sb);
            2'b10:   p = 64'(sa * ub);
            default: p = 64'(ua * ub);
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] absv(input logic [31:0] v, input bit s);
        return (s && v[31]) ? (32'h0 - v) : v;
    endfunction

    // Multiplier model: fixed or random latency, optional hold, forced or spurious ready
    bit mul_hold = 0;
    bit mul_force = 0;
    bit spur_en = 0;
    int lat_fixed = 4;
    int mul_cnt = 0;
    bit mul_act = 0;

    always @(posedge clk) begin
        #1;
        if (mul_force) begin
            mul_rdy = 1'b1;
            mul_res = {$urandom, $urandom};
        end else if (mul_vld) begin
            if (mul_hold) begin
                mul_rdy = 1'b0;
            end else begin
                if (!mul_act) begin
                    mul_act = 1;
                    mul_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
                end
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_rdy = 1'b1;
                    mul_res = 64'(mul_op1) * 64'(mul_op2);
                end else begin
                    mul_rdy = 1'b0;
                    mul_res = {$urandom, $urandom};
                end
            end
        end else begin
            mul_act = 0;
            mul_rdy = spur_en && ($urandom % 5 == 0);
            mul_res = {$urandom, $urandom};
        end
    end

    // Transaction model: one request outstanding, result visible until taken
    bit          m_on = 0;
    bit          m_pend = 0;
    bit          m_have = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;

    always @(negedge clk) begin
        logic [1:0] f;
        if (rst) begin
            m_pend = 0;
            m_have = 0;
            m_on = 1;
        end else if (m_on) begin
            chk("in_ready", 32'(in_ready), 32'(!m_pend));
            chk("out_valid", 32'(out_valid), 32'(m_have));
            chk("mul_vld", 32'(mul_vld), 32'(m_pend && !m_have));
            if (m_have) begin
                chk("out_result", out_result, m_res);
                chk("out_rd", 32'(out_rd), 32'(m_rd));
            end
            if (m_pend && !m_have) begin
                chk("mul_op1", mul_op1, m_op1);
                chk("mul_op2", mul_op2, m_op2);
            end
            if (!m_pend) begin
                if (in_valid) begin
                    f = in_funct3[1:0];
                    m_pend = 1;
                    m_rd = in_rd;
                    m_op1 = absv(in_rs1, (f == 2'b01) || (f == 2'b10));
                    m_op2 = absv(in_rs2, f == 2'b01);
                    m_res = ref_result(f, in_rs1, in_rs2);
                    m_have = (in_rs1 == 0) || (in_rs2 == 0);
                    n_acc++;
                end
            end else if (!m_have) begin
                if (mul_rdy) m_have = 1;
            end else if (out_ready) begin
                m_pend = 0;
                m_have = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail_now({nm, " in_ready"});
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " mul_vld"}, 32'(mul_vld), 32'd0);
        chk({nm, " out_result"}, out_result, 32'd0);
        chk({nm, " out_rd"}, 32'(out_rd), 32'd0);
        chk({nm, " mul_op1"}, mul_op1, 32'd0);
        chk({nm, " mul_op2"}, mul_op2, 32'd0);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit bypass,
                         input logic [31:0] eop1, input logic [31:0] eop2, input string nm);
        int n;
        wait_ready(nm);
        in_valid = 1'b1;
        in_funct3 = f;
        in_rs1 = a;
        in_rs2 = b;
        in_rd = rd;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        if (bypass) begin
            chk({nm, " bypass out_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " bypass mul_vld"}, 32'(mul_vld), 32'd0);
        end else begin
            chk({nm, " launch mul_vld"}, 32'(mul_vld), 32'd1);
            chk({nm, " mul_op1"}, mul_op1, eop1);
            chk({nm, " mul_op2"}, mul_op2, eop2);
        end
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            fail_now({nm, " out_valid"});
        end else begin
            chk({nm, " result"}, out_result, exp);
            chk({nm, " rd"}, 32'(out_rd), 32'(rd));
        end
        step();
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;
        step();
        chk_reset("post reset idle");

        lat_fixed = 4;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 0, 32'd7, 32'hFFFF_FFFD, "MUL 7*-3");
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 0, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFF, 0, 32'd1, 32'hFFFF_FFFF, "MULHSU -1*max");
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
        do_op(3'b101, 32'h0, 32'd5, 5'd12, 32'h0, 1, 32'h0, 32'h0, "MULH zero bypass");
        do_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd2, 32'hFFFF_FFFF, 0, 32'd2, 32'd3, "MULH -2*3");

        // Backpressure: hold the result while a second request waits
        wait_ready("bp");
        in_valid = 1'b1;
        in_funct3 = 3'b000;
        in_rs1 = 32'd7;
        in_rs2 = 32'd9;
        in_rd = 5'd3;
        out_ready = 1'b0;
        step();
        in_funct3 = 3'b011;
        in_rs1 = 32'd2;
        in_rs2 = 32'd3;
        in_rd = 5'd9;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail_now("bp out_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp out_result", out_result, 32'd63);
            chk("bp out_rd", 32'(out_rd), 32'd3);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp next accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_ready("bp drain");

        // Randomized traffic with random latency and stray mul_rdy
        lat_fixed = 0;
        spur_en = 1;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom % 3) != 0;
            in_funct3 = 3'($urandom);
            in_rd = 5'($urandom);
            case ($urandom % 8)
                0: in_rs1 = 32'h0;
                1: in_rs1 = 32'h8000_0000;
                2: in_rs1 = 32'hFFFF_FFFF;
                default: in_rs1 = $urandom;
            endcase
            case ($urandom % 8)
                0: in_rs2 = 32'h0;
                1: in_rs2 = 32'h8000_0000;
                2: in_rs2 = 32'hFFFF_FFFF;
                default: in_rs2 = $urandom;
            endcase
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        wait_ready("random drain");
        step();
        chk("random accepted enough", 32'(n_acc > 60), 32'd1);
        spur_en = 0;

        // Reset while BUSY abandons the request
        mul_hold = 1;
        wait_ready("rst busy");
        in_valid = 1'b1;
        in_funct3 = 3'b011;
        in_rs1 = 32'd3;
        in_rs2 = 32'd5;
        in_rd = 5'd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("rst busy mul_vld", 32'(mul_vld), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("rst busy");
        mul_hold = 0;
        mul_force = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abandoned out_valid", 32'(out_valid), 32'd0);
            chk("abandoned mul_vld", 32'(mul_vld), 32'd0);
            chk("abandoned in_ready", 32'(in_ready), 32'd1);
        end
        mul_force = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
